tdm_demux8: RTL and testbench
=============================

# tdm_demux8

Receive-side companion to the 8:1 bit multiplexer. It accepts a serial time-division-multiplexed bit stream, in which slot k carries channel k, together with a frame marker. It tracks slot position with a counter and a lock state machine, and rebuilds the 8 channel bits into a parallel word. One frame-valid pulse is produced per complete frame. The block sits at the far end of a link whose transmit side drives an 8:1 mux from a free-running 3-bit select.

## Interface
Parameters:
- NUM_CH, 8, number of TDM channels (slots per frame); must be a power of two.
- SLOT_W, 3, slot counter width; equals log2(NUM_CH).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial TDM data bit.
- din_valid  input  1  din carries a slot bit this cycle.
- frame_sync  input  1  qualified by din_valid; marks the current bit as slot 0.
- dout  output  NUM_CH  last complete frame; dout[k] is the bit received in slot k.
- frame_valid  output  1  one-cycle pulse when dout has just been updated.
- locked  output  1  high while in the LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing violation.
- slot  output  SLOT_W  index of the next expected slot.

## Operation
- A beat is a cycle with din_valid=1. Cycles with din_valid=0 change nothing, and frame_sync is ignored in those cycles.
- The state machine has two states, HUNT and LOCKED. Reset enters HUNT.
- **HUNT, beat with frame_sync=0:** the beat is discarded.
- **HUNT, beat with frame_sync=1:**
  - write shadow[0]=din and clear shadow[NUM_CH-1:1];
  - set slot=1 and go to LOCKED.
- **LOCKED, beat with slot≠0 and frame_sync=0:**
  - write shadow[slot]=din;
  - increment slot, wrapping NUM_CH-1 → 0.
- **Frame completion:** when the beat at slot=NUM_CH-1 is written:
  - dout takes the full shadow word, including that bit, on the same edge;
  - frame_valid pulses;
  - slot wraps to 0.
- **LOCKED, beat with slot=0 and frame_sync=1:** a normal frame start. Shadow[0]=din, the rest of shadow is cleared, slot=1.
- **LOCKED, beat with slot≠0 and frame_sync=1 (early sync):**
  - sync_err pulses;
  - the partial frame is discarded, so dout and frame_valid are unchanged;
  - the beat is treated as slot 0: shadow[0]=din, rest cleared, slot=1;
  - the block stays in LOCKED.
- **LOCKED, beat with slot=0 and frame_sync=0 (missing sync):**
  - sync_err pulses;
  - the beat is discarded and the block returns to HUNT;
  - slot=0 and dout holds its value.
- sync_err and frame_valid are never high in the same cycle. An early sync at slot NUM_CH-1 is an error and does not complete the frame.
- Slot arithmetic is modulo NUM_CH, unsigned, SLOT_W bits. No overflow flag exists.

## Timing
- Reset values: dout=0, frame_valid=0, locked=0, sync_err=0, slot=0. The shadow register is also cleared.
- Reset is sampled on the clock edge. Asserting it mid-frame clears all state on that edge, and outputs show their reset values the following cycle.
- All outputs are registered.
- Latency: dout and frame_valid become visible the cycle after the slot NUM_CH-1 beat is sampled.
- sync_err is visible the cycle after the offending beat.
- locked changes the cycle after the transition beat.
- Throughput: one beat per cycle, so back-to-back frames give one frame_valid every NUM_CH cycles with no bubble.
- Gaps in din_valid stretch a frame indefinitely. No timeout exists.
- dout is stable between frame_valid pulses.

## Structure
- Shared package tdm_pkg:
  - NUM_CH_DEF=8 and SLOT_W_DEF=3;
  - the state enum tdm_state_t {HUNT, LOCKED}.
  - The transmit-side counter uses the same package.
- One sub-module, demux1_8: a combinational 1-to-NUM_CH one-hot write-enable decoder (slot, en) → we[NUM_CH-1:0]. It is instantiated once to steer din into shadow.
- The top level holds:
  - the state register and slot counter;
  - the shadow and dout registers;
  - the pulse logic for frame_valid and sync_err.

## Test plan
- **Clean frame:** rst, then 8 consecutive beats with bits 1,0,1,1,0,0,1,0 (slot 0 first) and frame_sync on beat 0. Required: dout=8'b0100_1101, one frame_valid pulse one cycle after beat 7, locked=1.
- **Back-to-back frames:** frame A gives 8'hA5, immediately followed by frame B giving 8'h3C. Required: frame_valid exactly 8 cycles apart, dout=8'hA5 and then 8'h3C.
- **Gapped valid:** same bits as the clean frame, with din_valid=0 for 3 cycles after slot 2 and frame_sync=1 asserted during the gap. Required: the sync during the gap is ignored, slot holds at 3, and the final dout is identical to the clean-frame result.
- **Early sync:** frame_sync on the slot-5 beat. Required: sync_err pulses, no frame_valid, slot=1 next, locked stays 1. A complete frame after that yields a correct dout.
- **Missing sync:** 16 beats with frame_sync only on beat 0. Required: frame 1 completes, then sync_err pulses on beat 8, locked=0 and dout holds frame 1. Beats 9-15 are discarded.
- **Mid-frame reset:** rst asserted after 4 beats, then a clean frame. Required: all outputs are 0 the cycle after rst. The next frame_valid appears only after a fresh 8-beat frame, and the state starts from HUNT.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: default frame geometry and the receive lock state.
// The transmit-side slot counter uses the same package.
package tdm_pkg;

  localparam int unsigned NUM_CH_DEF = 8;
  localparam int unsigned SLOT_W_DEF = 3;

  typedef enum logic [0:0] {
    HUNT,
    LOCKED
  } tdm_state_t;

endpackage

// File: rtl/demux1_8.sv
// Combinational 1-to-NUM_CH one-hot write-enable decoder.
// Steers a single serial bit into one shadow register position.
module demux1_8 #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned SLOT_W = 3
) (
  input  logic [SLOT_W-1:0] slot,
  input  logic              en,
  output logic [NUM_CH-1:0] we
);

  always_comb begin
    we = '0;
    if (en) begin
      we[slot] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// Receive-side TDM demultiplexer: locks onto frame_sync, tracks the slot position and
// rebuilds each complete frame of NUM_CH serial bits into a parallel word.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [NUM_CH-1:0] dout,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err,
  output logic [SLOT_W-1:0] slot
);

  localparam logic [SLOT_W-1:0] SLOT_FIRST = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_CH - 1);

  tdm_state_t        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] dout_q, dout_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sync_err_q, sync_err_d;

  logic              wr_en;
  logic [NUM_CH-1:0] we;
  logic [NUM_CH-1:0] frame_start_word;

  // Ordinary in-frame write: slot 0 is only ever written by a sync beat.
  assign wr_en = din_valid & (state_q == LOCKED) & ~frame_sync & (slot_q != '0);

  demux1_8 #(
    .NUM_CH (NUM_CH),
    .SLOT_W (SLOT_W)
  ) u_demux (
    .slot (slot_q),
    .en   (wr_en),
    .we   (we)
  );

  always_comb begin
    frame_start_word    = '0;
    frame_start_word[0] = din;
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d = frame_start_word;
            slot_d   = SLOT_FIRST;
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A sync away from slot 0 drops the partial frame but keeps lock.
            sync_err_d = (slot_q != '0);
            shadow_d   = frame_start_word;
            slot_d     = SLOT_FIRST;
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            shadow_d = (shadow_q & ~we) | (we & {NUM_CH{din}});
            slot_d   = slot_q + SLOT_FIRST;
            if (slot_q == SLOT_LAST) begin
              dout_d        = shadow_d;
              frame_valid_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= '0;
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: directed scenarios plus a randomized run
// against a slot-position reference model.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] dout;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
  logic [2:0] slot;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state
  bit         m_lock;
  int         m_pos;
  bit [7:0]   m_buf;
  bit [7:0]   m_dout;
  bit         m_fv;
  bit         m_se;

  tdm_demux8 dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .slot        (slot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic v, input logic d, input logic fs);
    din_valid  = v;
    din        = d;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit v, input bit d, input bit fs);
    m_fv = 0;
    m_se = 0;
    if (r) begin
      m_lock = 0; m_pos = 0; m_buf = '0; m_dout = '0;
    end else if (v) begin
      if (!m_lock) begin
        if (fs) begin m_buf = '0; m_buf[0] = d; m_pos = 1; m_lock = 1; end
      end else if (fs) begin
        m_se = (m_pos != 0);
        m_buf = '0; m_buf[0] = d; m_pos = 1;
      end else if (m_pos == 0) begin
        m_se = 1; m_lock = 0;
      end else begin
        m_buf[m_pos] = d;
        if (m_pos == 7) begin m_dout = m_buf; m_fv = 1; end
        m_pos = (m_pos + 1) % 8;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_checks++; if ({frame_valid, locked, sync_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got fv/lk/se=%b want 000", {frame_valid, locked, sync_err}); end
    n_checks++; if (slot !== 3'd0) begin n_fail++; $display("FAIL reset_slot: got %0d want 0", slot); end
  endtask

  task automatic test_clean_frame();
    logic [7:0] w = 8'b0100_1101;
    int fv_cnt = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, w[k], k == 0);
      if (frame_valid) fv_cnt++;
      if (k == 6) begin
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL clean_early_fv: got %b want 0", frame_valid); end
      end
    end
    n_checks++; if (dout !== 8'h4D) begin n_fail++; $display("FAIL clean_dout: got %h want 4d", dout); end
    n_checks++; if (frame_valid !== 1'b1 || fv_cnt != 1) begin n_fail++; $display("FAIL clean_fv: got fv=%b count=%0d want 1/1", frame_valid, fv_cnt); end
    n_checks++; if (locked !== 1'b1 || slot !== 3'd0) begin n_fail++; $display("FAIL clean_lock: got locked=%b slot=%0d want 1/0", locked, slot); end
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (frame_valid !== 1'b0 || dout !== 8'h4D) begin n_fail++; $display("FAIL clean_hold: got fv=%b dout=%h want 0/4d", frame_valid, dout); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ws = 16'h3CA5;
    int t1 = -1, t2 = -1, fv_cnt = 0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(1'b1, ws[k], (k % 8) == 0);
      if (frame_valid) begin
        fv_cnt++;
        if (k == 7) begin
          t1 = cyc;
          n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL b2b_dout_a: got %h want a5", dout); end
        end
        if (k == 15) begin
          t2 = cyc;
          n_checks++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL b2b_dout_b: got %h want 3c", dout); end
        end
      end
    end
    n_checks++; if (fv_cnt != 2 || t1 < 0 || t2 < 0 || (t2 - t1) != 8) begin n_fail++; $display("FAIL b2b_spacing: got count=%0d spacing=%0d want 2/8", fv_cnt, t2 - t1); end
  endtask

  task automatic test_gapped();
    logic [7:0] w = 8'b0100_1101;
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, w[k], k == 0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1, 1'b1);
      n_checks++; if (slot !== 3'd3 || sync_err !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL gap_hold: got slot=%0d se=%b lk=%b want 3/0/1", slot, sync_err, locked); end
    end
    for (int k = 3; k < 8; k++) step(1'b1, w[k], 1'b0);
    n_checks++; if (dout !== 8'h4D || frame_valid !== 1'b1) begin n_fail++; $display("FAIL gap_dout: got dout=%h fv=%b want 4d/1", dout, frame_valid); end
  endtask

  task automatic test_early_sync();
    logic [7:0] w = 8'h96;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, k[0], k == 0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k == 0);
    step(1'b1, w[0], 1'b1);
    n_checks++; if (sync_err !== 1'b1 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL early_pulse: got se=%b fv=%b want 1/0", sync_err, frame_valid); end
    n_checks++; if (slot !== 3'd1 || locked !== 1'b1 || dout !== 8'hAA) begin n_fail++; $display("FAIL early_state: got slot=%0d lk=%b dout=%h want 1/1/aa", slot, locked, dout); end
    for (int k = 1; k < 8; k++) step(1'b1, w[k], 1'b0);
    n_checks++; if (dout !== 8'h96 || frame_valid !== 1'b1 || sync_err !== 1'b0) begin n_fail++; $display("FAIL early_next: got dout=%h fv=%b se=%b want 96/1/0", dout, frame_valid, sync_err); end
  endtask

  task automatic test_missing_sync();
    logic [7:0] w = 8'h5B;
    int bad = 0;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, w[k], k == 0);
    n_checks++; if (dout !== 8'h5B || frame_valid !== 1'b1) begin n_fail++; $display("FAIL miss_frame1: got dout=%h fv=%b want 5b/1", dout, frame_valid); end
    step(1'b1, 1'b1, 1'b0);
    n_checks++; if (sync_err !== 1'b1 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL miss_pulse: got se=%b fv=%b want 1/0", sync_err, frame_valid); end
    n_checks++; if (locked !== 1'b0 || slot !== 3'd0 || dout !== 8'h5B) begin n_fail++; $display("FAIL miss_state: got lk=%b slot=%0d dout=%h want 0/0/5b", locked, slot, dout); end
    for (int k = 9; k < 16; k++) begin
      step(1'b1, k[0], 1'b0);
      if (frame_valid || sync_err || locked || slot != 3'd0 || dout != 8'h5B) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL miss_discard: got %0d disturbed cycles want 0", bad); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] w = 8'b0100_1101;
    int fv_cnt = 0;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, k == 0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, k == 0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    n_checks++; if ({dout, frame_valid, locked, sync_err, slot} !== 14'd0) begin n_fail++; $display("FAIL midrst_outputs: got dout=%h fv=%b lk=%b se=%b slot=%0d want all 0", dout, frame_valid, locked, sync_err, slot); end
    step(1'b1, 1'b1, 1'b0);
    n_checks++; if (locked !== 1'b0 || sync_err !== 1'b0) begin n_fail++; $display("FAIL midrst_hunt: got lk=%b se=%b want 0/0", locked, sync_err); end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, w[k], k == 0);
      if (frame_valid) fv_cnt++;
    end
    n_checks++; if (fv_cnt != 1 || frame_valid !== 1'b1 || dout !== 8'h4D) begin n_fail++; $display("FAIL midrst_frame: got count=%0d fv=%b dout=%h want 1/1/4d", fv_cnt, frame_valid, dout); end
  endtask

  task automatic test_random();
    bit r, v, d, fs;
    int errs = 0;
    do_reset();
    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1);
      fs = (m_pos == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
      rst = r;
      step(v, d, fs);
      rst = 1'b0;
      model_step(r, v, d, fs);
      n_checks++;
      if (dout !== m_dout || frame_valid !== m_fv || sync_err !== m_se ||
          locked !== m_lock || slot !== 3'(m_pos)) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random_cycle%0d: got dout=%h fv=%b se=%b lk=%b slot=%0d want %h/%b/%b/%b/%0d",
                   i, dout, frame_valid, sync_err, locked, slot, m_dout, m_fv, m_se, m_lock, m_pos);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_back_to_back();
    test_gapped();
    test_early_sync();
    test_missing_sync();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
